hazard_scoreboard: RTL and testbench

- Parametrised successor to the combinational load-use hazard check in the ID stage of the pipelined MIPS core.
- Keeps a per-register countdown scoreboard of pending long-latency results: loads, multi-cycle mult/div, or any unit with latency set at issue.
- Stalls PC/IF-ID and bubbles ID/EX until every source read in ID is forwardable.
- Adds a stall watchdog and optional stall-cycle performance counting.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_sb_entry.sv | 28 ++
 rtl/hazard_scoreboard.sv | 83 ++++++++
 tb/tb_hazard_scoreboard.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults and latency codes for the hazard scoreboard.
// Optional stall-cycle counting is enabled by defining HAZARD_PERF_EN.
package hazard_pkg;

  localparam int REG_W_DEF = 5;
  localparam int LAT_W_DEF = 3;

  localparam logic [LAT_W_DEF-1:0] LAT_NONE    = 3'd0;
  localparam logic [LAT_W_DEF-1:0] LAT_LOAD    = 3'd1;
  localparam logic [LAT_W_DEF-1:0] LAT_LOAD_WB = 3'd2;
  localparam logic [LAT_W_DEF-1:0] LAT_MULDIV  = 3'd5;

  typedef logic [2**REG_W_DEF-1:0] busy_vec_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown to zero, reloaded with the larger of the
// decremented value and a newly issued latency.
module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt
);

  logic [LAT_W-1:0] dec;
  logic [LAT_W-1:0] nxt;

  always_comb begin
    dec = (cnt != '0) ? cnt - LAT_W'(1) : '0;
    nxt = dec;
    // keep whichever pending result finishes later
    if (load && (lat > dec)) nxt = lat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= nxt;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls ID until its sources are
// forwardable, with a stall watchdog. HAZARD_PERF_EN builds stall_cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int LAT_W     = LAT_W_DEF,
  parameter int MAX_STALL = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_W-1:0]    id_rs,
  input  logic                id_rs_used,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_rt_used,
  input  logic                iss_valid,
  input  logic [REG_W-1:0]    iss_rd,
  input  logic [LAT_W-1:0]    iss_lat,
  output logic                stall,
  output logic                flush_idex,
  output logic [2**REG_W-1:0] busy_vec,
  output logic                stall_err,
  output logic [31:0]         stall_cycles
);

  localparam int NREG = 2**REG_W;

  logic [LAT_W-1:0] cnt [NREG];
  logic             hit_s;
  logic             hit_t;
  logic             issue;
  logic [7:0]       run_cnt;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (issue && (iss_rd == REG_W'(r)) && (iss_lat != '0)),
      .lat   (iss_lat),
      .cnt   (cnt[r])
    );
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREG; r++) busy_vec[r] = (cnt[r] != '0);
  end

  assign hit_s      = id_rs_used && (id_rs != '0) && (cnt[id_rs] != '0);
  assign hit_t      = id_rt_used && (id_rt != '0) && (cnt[id_rt] != '0);
  assign stall      = hit_s || hit_t;
  assign flush_idex = stall;
  assign issue      = iss_valid && !stall;

  // error is flagged on the edge that closes the MAX_STALL-th stalled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt   <= '0;
      stall_err <= 1'b0;
    end else if (stall) begin
      if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
      if (({1'b0, run_cnt} + 9'd1) >= 9'(MAX_STALL)) stall_err <= 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         perf_q <= '0;
    else if (stall && (perf_q != '1))   perf_q <= perf_q + 32'd1;
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; counters widened to 4 bits so a
// single 15-cycle producer can exercise the MAX_STALL=15 watchdog.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int REG_W = 5;
  localparam int LAT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs, id_rt, iss_rd;
  logic             id_rs_used, id_rt_used, iss_valid;
  logic [LAT_W-1:0] iss_lat;
  logic             stall, flush_idex, stall_err;
  busy_vec_t        busy_vec;
  logic [31:0]      stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;
  int n_st;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_scoreboard #(.REG_W(REG_W), .LAT_W(LAT_W), .MAX_STALL(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .stall(stall), .flush_idex(flush_idex), .busy_vec(busy_vec),
    .stall_err(stall_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rs_used = 1'b0;
    id_rt = '0; id_rt_used = 1'b0;
    iss_valid = 1'b0; iss_rd = '0; iss_lat = '0;
  endtask

  task automatic issue(input logic [REG_W-1:0] rd, input logic [LAT_W-1:0] lat);
    idle();
    iss_valid = 1'b1; iss_rd = rd; iss_lat = lat;
    #1;
    cyc();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // count consecutive stalled cycles; returns once stall is low (pre-edge)
  task automatic count_stall(output int n);
    n = 0;
    #1;
    while (stall && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) check("stall_bound", 64'(n), 64'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_vec), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_err", 64'(stall_err), 64'd0);
    check("rst_perf", 64'(stall_cycles), 64'd0);
    rst_n = 1'b1;
    cyc();

    // load-use on rs
    issue(5'd8, 4'd1);
    check("lu_busy", 64'(busy_vec), 64'h100);
    idle();
    id_rs = 5'd8; id_rs_used = 1'b1; iss_valid = 1'b1; iss_rd = 5'd10; iss_lat = 4'd0;
    #1;
    check("lu_stall", 64'(stall), 64'd1);
    check("lu_flush", 64'(flush_idex), 64'd1);
    cyc();
    check("lu_release", 64'(stall), 64'd0);
    check("lu_busy_clr", 64'(busy_vec), 64'd0);
    cyc();
    // rt matches but unused
    issue(5'd8, 4'd1);
    idle();
    id_rt = 5'd8; id_rt_used = 1'b0; iss_valid = 1'b1;
    #1;
    check("lu_rt_unused", 64'(stall), 64'd0);
    cyc();

    // multi-cycle producer, consumer on rt tries to issue a tracked result while stalled
    do_reset();
    issue(5'd4, 4'd5);
    idle();
    id_rt = 5'd4; id_rt_used = 1'b1; iss_valid = 1'b1; iss_rd = 5'd12; iss_lat = 4'd3;
    count_stall(n_st);
    check("mul_stall_len", 64'(n_st), 64'd5);
    check("mul_no_upd", 64'(busy_vec), 64'd0);
    check("mul_perf", 64'(stall_cycles), PERF ? 64'd5 : 64'd0);
    cyc();
    check("mul_issued", 64'(busy_vec), 64'h1000);
    idle();

    // same-register collision keeps the longer result
    do_reset();
    issue(5'd3, 4'd5);
    idle();
    cyc();
    issue(5'd3, 4'd1);
    check("col_busy", 64'(busy_vec), 64'h8);
    idle();
    id_rs = 5'd3; id_rs_used = 1'b1;
    count_stall(n_st);
    check("col_max_rule", 64'(n_st), 64'd3);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd0; iss_lat = 4'd7;
    id_rs = 5'd0; id_rs_used = 1'b1; id_rt = 5'd0; id_rt_used = 1'b1;
    #1;
    check("r0_no_stall", 64'(stall), 64'd0);
    cyc();
    check("r0_no_track", 64'(busy_vec), 64'd0);
    check("r0_no_stall2", 64'(stall), 64'd0);

    // watchdog: a 15-cycle producer gives exactly 15 consecutive stalls
    do_reset();
    issue(5'd7, 4'd15);
    idle();
    id_rs = 5'd7; id_rs_used = 1'b1;
    #1;
    for (int i = 0; i < 14; i++) cyc();
    check("wd_still_stall", 64'(stall), 64'd1);
    check("wd_err_14", 64'(stall_err), 64'd0);
    cyc();
    check("wd_stall_drop", 64'(stall), 64'd0);
    check("wd_err_15", 64'(stall_err), 64'd1);
    idle();
    repeat (3) cyc();
    check("wd_err_sticky", 64'(stall_err), 64'd1);
    check("wd_perf", 64'(stall_cycles), PERF ? 64'd15 : 64'd0);

    // reset while stalled (err still set from the watchdog run)
    issue(5'd9, 4'd3);
    idle();
    id_rs = 5'd9; id_rs_used = 1'b1;
    #1;
    check("rm_pre_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #2;
    check("rm_busy", 64'(busy_vec), 64'd0);
    check("rm_stall", 64'(stall), 64'd0);
    check("rm_err", 64'(stall_err), 64'd0);
    check("rm_perf", 64'(stall_cycles), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rm_after", 64'(stall), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
